// File: rtl/marin_wb_arbiter.sv
// Two-master Wishbone arbiter. Grants the bus to one master at a time with
// round-robin tie-break and issues an error when a strobed access waits too long.
module marin_wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  output logic [1:0]              gnt_o,
  output logic                    tmo_o
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_last;
  logic [7:0]              r_cnt;
  logic                    r_mask;

  logic                    w_cyc;
  logic                    w_stb;
  logic                    w_we;
  logic [DATA_WIDTH/8-1:0] w_sel;
  logic [ADDR_WIDTH-1:0]   w_adr;
  logic [DATA_WIDTH-1:0]   w_dat;
  logic                    w_resp;
  logic                    w_active;
  logic                    w_tmo;

  // Select the current owner's bus signals; all zero when idle.
  always_comb begin
    w_cyc = 1'b0;
    w_stb = 1'b0;
    w_we  = 1'b0;
    w_sel = '0;
    w_adr = '0;
    w_dat = '0;
    case (r_state)
      GNT0: begin
        w_cyc = m0_cyc_i;
        w_stb = m0_stb_i;
        w_we  = m0_we_i;
        w_sel = m0_sel_i;
        w_adr = m0_adr_i;
        w_dat = m0_dat_i;
      end
      GNT1: begin
        w_cyc = m1_cyc_i;
        w_stb = m1_stb_i;
        w_we  = m1_we_i;
        w_sel = m1_sel_i;
        w_adr = m1_adr_i;
        w_dat = m1_dat_i;
      end
      default: begin
        w_cyc = 1'b0;
        w_stb = 1'b0;
      end
    endcase
  end

  assign w_resp   = s_ack_i | s_err_i;
  assign w_active = w_cyc & w_stb;
  // A real slave response on the limit cycle wins over the timeout.
  assign w_tmo    = w_active & ~w_resp & (r_cnt == TMO_LAST);

  // Next-state arbitration; owner keeps the bus until it drops cyc.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_next = r_last ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          w_next = GNT0;
        end else if (m1_cyc_i) begin
          w_next = GNT1;
        end else begin
          w_next = IDLE;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          w_next = IDLE;
        end else begin
          w_next = GNT0;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          w_next = IDLE;
        end else begin
          w_next = GNT1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, last-grant record, timeout counter and post-timeout strobe mask.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= 8'd0;
      r_mask  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mask  <= w_tmo;
      if ((r_state == GNT0) && !m0_cyc_i) begin
        r_last <= 1'b0;
      end else if ((r_state == GNT1) && !m1_cyc_i) begin
        r_last <= 1'b1;
      end else begin
        r_last <= r_last;
      end
      if (!w_active || w_resp || w_tmo) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign gnt_o    = {(r_state == GNT1), (r_state == GNT0)};
  assign tmo_o    = w_tmo;

  assign s_cyc_o  = w_cyc;
  assign s_stb_o  = w_stb & ~r_mask;
  assign s_we_o   = w_we;
  assign s_sel_o  = w_sel;
  assign s_adr_o  = w_adr;
  assign s_dat_o  = w_dat;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (r_state == GNT0) & s_ack_i;
  assign m1_ack_o = (r_state == GNT1) & s_ack_i;
  assign m0_err_o = (r_state == GNT0) & (s_err_i | w_tmo);
  assign m1_err_o = (r_state == GNT1) & (s_err_i | w_tmo);

endmodule

// File: tb/tb_marin_wb_arbiter.sv
// Randomized bench for marin_wb_arbiter against a cycle-level reference model
// of the ownership, round-robin and timeout rules.
module tb_marin_wb_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [DW/8-1:0] m0_sel, m1_sel, s_sel;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_wd, m1_wd, m0_rd, m1_rd, s_wd, s_rd;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we, s_ack, s_err, tmo;
  logic [1:0]    gnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: owner is -1 when idle.
  int owner;
  int last_owner;
  int waited;
  bit masked;
  bit exp_tmo;

  always #5 clk = ~clk;

  marin_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wd), .m0_dat_o(m0_rd), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wd), .m1_dat_o(m1_rd), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wd), .s_dat_i(s_rd), .s_ack_i(s_ack),
    .s_err_i(s_err), .gnt_o(gnt), .tmo_o(tmo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit own_cyc();
    return (owner == 0) ? m0_cyc : (owner == 1) ? m1_cyc : 1'b0;
  endfunction

  function automatic bit own_stb();
    return (owner == 0) ? m0_stb : (owner == 1) ? m1_stb : 1'b0;
  endfunction

  // Compare every DUT output with what the rules say for the current inputs.
  task automatic check_outputs();
    bit resp;
    bit act;
    logic [1:0] e_gnt;
    resp    = s_ack | s_err;
    act     = own_cyc() && own_stb();
    exp_tmo = act && !resp && (waited == TMO - 1);
    e_gnt   = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    check_eq("gnt", 64'(gnt), 64'(e_gnt));
    check_eq("tmo", 64'(tmo), 64'(exp_tmo));
    check_eq("s_cyc", 64'(s_cyc), 64'(own_cyc()));
    check_eq("s_stb", 64'(s_stb), 64'(own_stb() && !masked));
    check_eq("s_we", 64'(s_we), 64'((owner == 0) ? m0_we : (owner == 1) ? m1_we : 1'b0));
    check_eq("s_sel", 64'(s_sel), 64'((owner == 0) ? m0_sel : (owner == 1) ? m1_sel : 4'h0));
    check_eq("s_adr", 64'(s_adr), 64'((owner == 0) ? m0_adr : (owner == 1) ? m1_adr : 32'h0));
    check_eq("s_dat", 64'(s_wd), 64'((owner == 0) ? m0_wd : (owner == 1) ? m1_wd : 32'h0));
    check_eq("m0_dat", 64'(m0_rd), 64'(s_rd));
    check_eq("m1_dat", 64'(m1_rd), 64'(s_rd));
    check_eq("m0_ack", 64'(m0_ack), 64'((owner == 0) && s_ack));
    check_eq("m1_ack", 64'(m1_ack), 64'((owner == 1) && s_ack));
    check_eq("m0_err", 64'(m0_err), 64'((owner == 0) && (s_err || exp_tmo)));
    check_eq("m1_err", 64'(m1_err), 64'((owner == 1) && (s_err || exp_tmo)));
  endtask

  // Advance the model across a rising edge using the inputs just applied.
  task automatic model_edge();
    bit resp;
    bit act;
    resp = s_ack | s_err;
    act  = own_cyc() && own_stb();
    if (rst) begin
      owner = -1; last_owner = 1; waited = 0; masked = 1'b0;
    end else begin
      masked = exp_tmo;
      waited = (!act || resp || exp_tmo) ? 0 : waited + 1;
      if (owner < 0) begin
        if (m0_cyc && m1_cyc) owner = 1 - last_owner;
        else if (m0_cyc)      owner = 0;
        else if (m1_cyc)      owner = 1;
      end else if (!own_cyc()) begin
        last_owner = owner;
        owner = -1;
      end
    end
  endtask

  // One cycle: drive at the falling edge, check mid-low phase, update at the rise.
  task automatic step(input bit r, input bit c0, input bit s0, input bit c1, input bit s1,
                      input bit ack, input bit err);
    @(negedge clk);
    rst = r; m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1;
    s_ack = ack; s_err = err;
    m0_we = 1'($urandom); m1_we = 1'($urandom);
    m0_sel = 4'($urandom); m1_sel = 4'($urandom);
    m0_adr = $urandom; m1_adr = $urandom;
    m0_wd = $urandom; m1_wd = $urandom; s_rd = $urandom;
    #2;
    check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    bit c0, s0, c1, s1;
    owner = -1; last_owner = 1; waited = 0; masked = 1'b0; exp_tmo = 1'b0;
    rst = 1'b1; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    m0_we = 1'b0; m1_we = 1'b0; m0_sel = '0; m1_sel = '0; m0_adr = '0; m1_adr = '0;
    m0_wd = '0; m1_wd = '0; s_rd = '0; s_ack = 1'b0; s_err = 1'b0;
    @(posedge clk);
    step(1'b1, 0, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0, 0, 0);

    // Simultaneous request after reset: m0 first, then m1 after a dead cycle.
    repeat (3) step(1'b0, 1, 0, 1, 0, 0, 0);
    repeat (3) step(1'b0, 0, 0, 1, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0, 0);

    // m1 holds the bus across four acked transfers while m0 waits.
    step(1'b0, 0, 0, 1, 0, 0, 0);
    repeat (4) step(1'b0, 1, 1, 1, 1, 1, 0);
    repeat (3) step(1'b0, 1, 1, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0, 0);

    // Timeout on m0, then an ack on the limit cycle suppresses it.
    step(1'b0, 1, 1, 0, 0, 0, 0);
    repeat (6) step(1'b0, 1, 1, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 1, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) step(1'b0, 1, 1, 0, 0, (k == 4), 0);
    step(1'b0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0, 0);

    // Slave error during an m1 access.
    step(1'b0, 0, 0, 1, 1, 0, 0);
    step(1'b0, 0, 0, 1, 1, 0, 1);
    step(1'b0, 0, 0, 0, 0, 0, 0);

    // Reset while m1 strobes, then a tie must go to m0.
    step(1'b0, 0, 0, 1, 1, 0, 0);
    step(1'b0, 0, 0, 1, 1, 0, 0);
    step(1'b1, 0, 0, 1, 1, 0, 0);
    repeat (3) step(1'b0, 1, 0, 1, 0, 0, 0);

    // Randomized traffic with sticky cyc lines.
    c0 = 1'b0; c1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) c0 = ~c0;
      if ($urandom_range(0, 7) == 0) c1 = ~c1;
      s0 = c0 && ($urandom_range(0, 3) != 0);
      s1 = c1 && ($urandom_range(0, 3) != 0);
      step(($urandom_range(0, 199) == 0), c0, s0, c1, s1,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/marin_wb_arbiter.md
MARIN_WB_ARBITER -- requirements
Module: marin_wb_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; TIMEOUT, 255, max cycles a strobed access may wait for ack/err (range 1..255).
REQ-002 clk_i  in  1  system clock; all logic rising-edge.
REQ-003 rst_i  in  1  reset; synchronous, active-high.
REQ-004 mN_cyc_i (N=0,1)  in  1  master N bus cycle request/hold.
REQ-005 mN_stb_i  in  1  master N strobe.
REQ-006 mN_we_i  in  1  master N write enable.
REQ-007 mN_sel_i  in  DATA_WIDTH/8  master N byte selects.
REQ-008 mN_adr_i  in  ADDR_WIDTH  master N address.
REQ-009 mN_dat_i  in  DATA_WIDTH  master N write data.
REQ-010 mN_dat_o  out  DATA_WIDTH  read data to master N.
REQ-011 mN_ack_o  out  1  ack to master N.
REQ-012 mN_err_o  out  1  error to master N (slave err or timeout).
REQ-013 s_cyc_o, s_stb_o, s_we_o  out  1 each  shared slave-side controls.
REQ-014 s_sel_o  out  DATA_WIDTH/8; s_adr_o  out  ADDR_WIDTH; s_dat_o  out  DATA_WIDTH.
REQ-015 s_dat_i  in  DATA_WIDTH; s_ack_i  in  1; s_err_i  in  1  slave responses.
REQ-016 gnt_o  out  2  one-hot current owner (bit N = master N), 2'b00 when idle.
REQ-017 tmo_o  out  1  one-cycle pulse when a timeout error is issued.

Function
REQ-018 FSM states SHALL be IDLE, GNT0, GNT1; gnt_o SHALL be decoded from state only.
REQ-019 IDLE: only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1; both -> grant the master not recorded in last_grant; neither -> stay IDLE.
REQ-020 Grant latency SHALL be one cycle: request sampled in IDLE, bus driven from the following cycle.
REQ-021 In GNTn, s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL combinationally follow master n; in IDLE s_cyc_o=s_stb_o=0 and other slave outputs 0.
REQ-022 mN_dat_o SHALL equal s_dat_i for both masters; mN_ack_o/mN_err_o SHALL be forced 0 for the non-owner.
REQ-023 Owner SHALL hold the bus for as long as its cyc is high (back-to-back and locked transfers uninterrupted); no preemption.
REQ-024 Owner dropping cyc SHALL return FSM to IDLE next cycle and set last_grant=owner; re-arbitration occurs in that IDLE cycle (one dead cycle between owners).
REQ-025 Timeout counter (8 bits) SHALL clear when not in GNTn, when owner stb low, or on s_ack_i/s_err_i; otherwise increment each cycle.
REQ-026 When counter equals TIMEOUT-1 with owner stb high and no slave response, owner mN_err_o and tmo_o SHALL assert that cycle for one cycle, counter clears, and s_stb_o SHALL be masked low the next cycle.
REQ-027 Slave ack/err arriving on the same cycle as timeout SHALL take priority: pass through, no tmo_o.
REQ-028 s_ack_i/s_err_i while IDLE SHALL be ignored (no master response).
REQ-029 Owner cyc dropping with stb high mid-transfer SHALL still release per REQ-024; counter clears.

Reset
REQ-030 On rst_i: state=IDLE, last_grant=1 (m0 wins first contention), counter=0, tmo_o=0, gnt_o=0, strobe mask clear.
REQ-031 Reset asserted mid-transfer SHALL force s_cyc_o=s_stb_o=0 from the next edge regardless of master inputs.

Verification
REQ-032 After reset, m0_cyc/m1_cyc both rise same cycle -> gnt_o=01 next cycle; m0 drops cyc -> IDLE one cycle -> gnt_o=10.
REQ-033 m1 owns bus, m0 requests, m1 holds cyc for 4 ack'd transfers -> all 4 acks on m1_ack_o only, gnt_o=10 throughout, m0_ack_o=0.
REQ-034 TIMEOUT=4, m0 strobes, slave never acks -> m0_err_o and tmo_o high on 4th strobed cycle, s_stb_o low next cycle.
REQ-035 TIMEOUT=4, s_ack_i on the 4th strobed cycle -> m0_ack_o=1, m0_err_o=0, tmo_o=0.
REQ-036 rst_i asserted while gnt_o=10 with stb high -> s_cyc_o=0, gnt_o=00 next cycle; subsequent simultaneous request granted to m0.
REQ-037 s_err_i during m1 read -> m1_err_o=1 same cycle, m0_err_o=0, tmo_o=0.
